ps2_kbd_uknc: RTL and testbench

PS2_KBD_UKNC -- requirements
Module: ps2_kbd_uknc

---
 rtl/uknc_kbd_pkg.sv | 45 ++++
 rtl/ps2_uknc_map.sv | 11 +
 rtl/ps2_kbd_uknc.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_kbd_uknc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uknc_kbd_pkg.sv
// Shared constants for the PS/2 to UKNC keyboard bridge: decoder states,
// scan-code prefixes, bytes ignored between keystrokes and the key map.
package uknc_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } dec_state_t;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    // Pause sends E1 followed by seven more bytes that carry no key.
    localparam logic [3:0] PAUSE_SKIP_LEN = 4'd7;

    localparam logic [7:0] IGN_BAT    = 8'hAA;
    localparam logic [7:0] IGN_ACK    = 8'hFA;
    localparam logic [7:0] IGN_ECHO   = 8'hEE;
    localparam logic [7:0] IGN_RESEND = 8'hFE;
    localparam logic [7:0] IGN_OVRUN  = 8'h00;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == IGN_BAT) || (b == IGN_ACK) || (b == IGN_ECHO) ||
               (b == IGN_RESEND) || (b == IGN_OVRUN);
    endfunction

    // Key is {extended, scan code}; a result of 0 means the key has no UKNC equivalent.
    function automatic logic [6:0] map_lookup(input logic [8:0] key);
        logic [6:0] code;
        code = 7'o000;
        case (key)
            {1'b0, 8'h1C}: code = 7'o072;
            {1'b0, 8'h5A}: code = 7'o153;
            {1'b1, 8'h75}: code = 7'o154;
            {1'b0, 8'h29}: code = 7'o113;
            default:       code = 7'o000;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ps2_uknc_map.sv
// Combinational scan-code to UKNC key-code translation.
module ps2_uknc_map
    import uknc_kbd_pkg::*;
(
    input  logic [8:0] key_i,
    output logic [6:0] code_o
);

    assign code_o = map_lookup(key_i);

endmodule

// File: rtl/ps2_kbd_uknc.sv
// PS/2 keyboard receiver: line conditioning, frame assembly and translation
// of make/break sequences into UKNC key codes.
module ps2_kbd_uknc
    import uknc_kbd_pkg::*;
#(
    parameter int FILT        = 8,
    parameter int TIMEOUT_CYC = 4000
) (
    input  logic       pin_vm_clk_p,
    input  logic       pin_vm_init_i,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] but_data,
    output logic       kbd_stb,
    output logic       kbd_err
);

    localparam int FW = $clog2(FILT + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0] raw_in;
    logic [1:0] line_f;

    assign raw_in = {ps2_dat, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic          sync0_q, sync1_q, filt_q, filt_d;
            logic [FW-1:0] fcnt_q, fcnt_d;

            // Level only moves after FILT consecutive samples disagree with it.
            always_comb begin
                filt_d = filt_q;
                fcnt_d = '0;
                if (sync1_q != filt_q) begin
                    if (fcnt_q == FW'(FILT - 1)) begin
                        filt_d = sync1_q;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge pin_vm_clk_p) begin
                if (pin_vm_init_i) begin
                    sync0_q <= 1'b1;
                    sync1_q <= 1'b1;
                    filt_q  <= 1'b1;
                    fcnt_q  <= '0;
                end else begin
                    sync0_q <= raw_in[gi];
                    sync1_q <= sync0_q;
                    filt_q  <= filt_d;
                    fcnt_q  <= fcnt_d;
                end
            end

            assign line_f[gi] = filt_q;
        end
    endgenerate

    logic clk_f, dat_f, clk_prev_q, ps2_fall;
    assign clk_f    = line_f[0];
    assign dat_f    = line_f[1];
    assign ps2_fall = clk_prev_q & ~clk_f;

    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_vld_q, rx_vld_d;
    logic          rx_err_q, rx_err_d;

    // shift_q collects data bits then parity; bit 8 is parity after nine shifts.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        rx_byte_d = rx_byte_q;
        rx_vld_d  = 1'b0;
        rx_err_d  = 1'b0;
        if (ps2_fall) begin
            tmo_d = '0;
            if (bit_cnt_q == 4'd0) begin
                if (!dat_f) begin
                    bit_cnt_d = 4'd1;
                end
            end else if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (dat_f && (^shift_q)) begin
                    rx_vld_d  = 1'b1;
                    rx_byte_d = shift_q[7:0];
                end else begin
                    rx_err_d = 1'b1;
                end
            end else begin
                shift_d   = {dat_f, shift_q[8:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                bit_cnt_d = 4'd0;
                tmo_d     = '0;
                rx_err_d  = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge pin_vm_clk_p) begin
        if (pin_vm_init_i) begin
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            tmo_q      <= '0;
            rx_byte_q  <= '0;
            rx_vld_q   <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            clk_prev_q <= clk_f;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            rx_byte_q  <= rx_byte_d;
            rx_vld_q   <= rx_vld_d;
            rx_err_q   <= rx_err_d;
        end
    end

    dec_state_t state_q;
    logic [3:0] skip_q;
    logic [6:0] held_code_q;
    logic       held_valid_q;
    logic [7:0] but_data_q;
    logic       kbd_stb_q, kbd_err_q;
    logic [6:0] map_code;
    logic       dec_ext, dec_brk;

    assign dec_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign dec_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

    ps2_uknc_map u_map (
        .key_i  ({dec_ext, rx_byte_q}),
        .code_o (map_code)
    );

    // Errors are delayed one stage so they line up with kbd_stb timing;
    // a frame yields either a byte or an error, so the two never coincide.
    always_ff @(posedge pin_vm_clk_p) begin
        if (pin_vm_init_i) begin
            state_q      <= ST_IDLE;
            skip_q       <= 4'd0;
            held_code_q  <= 7'd0;
            held_valid_q <= 1'b0;
            but_data_q   <= 8'd0;
            kbd_stb_q    <= 1'b0;
            kbd_err_q    <= 1'b0;
        end else begin
            kbd_stb_q <= 1'b0;
            kbd_err_q <= rx_err_q;
            if (rx_vld_q) begin
                if (state_q == ST_SKIP) begin
                    skip_q <= skip_q - 4'd1;
                    if (skip_q == 4'd1) begin
                        state_q <= ST_IDLE;
                    end
                end else if (rx_byte_q == PFX_EXT) begin
                    if (state_q == ST_IDLE) begin
                        state_q <= ST_EXT;
                    end else if (state_q == ST_BRK) begin
                        state_q <= ST_EXT_BRK;
                    end
                end else if (rx_byte_q == PFX_BRK) begin
                    if (state_q == ST_IDLE) begin
                        state_q <= ST_BRK;
                    end else if (state_q == ST_EXT) begin
                        state_q <= ST_EXT_BRK;
                    end
                end else if ((rx_byte_q == PFX_PAUSE) && (state_q == ST_IDLE)) begin
                    state_q <= ST_SKIP;
                    skip_q  <= PAUSE_SKIP_LEN;
                end else if (is_ignored(rx_byte_q) && (state_q == ST_IDLE)) begin
                    state_q <= ST_IDLE;
                end else begin
                    state_q <= ST_IDLE;
                    if (map_code != 7'd0) begin
                        if (!dec_brk) begin
                            if (!held_valid_q || (map_code != held_code_q)) begin
                                but_data_q   <= {1'b0, map_code};
                                held_code_q  <= map_code;
                                held_valid_q <= 1'b1;
                                kbd_stb_q    <= 1'b1;
                            end
                        end else if (held_valid_q && (map_code == held_code_q)) begin
                            but_data_q   <= {1'b1, map_code};
                            held_valid_q <= 1'b0;
                            kbd_stb_q    <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign but_data = but_data_q;
    assign kbd_stb  = kbd_stb_q;
    assign kbd_err  = kbd_err_q;

endmodule

// File: tb/tb_ps2_kbd_uknc.sv
// Directed bench for ps2_kbd_uknc with a keystroke-level reference model.
module tb_ps2_kbd_uknc;

    localparam int FILT = 8;
    localparam int TMO  = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] but_data;
    logic       kbd_stb, kbd_err;

    always #5 clk = ~clk;

    ps2_kbd_uknc #(.FILT(FILT), .TIMEOUT_CYC(TMO)) dut (
        .pin_vm_clk_p  (clk),
        .pin_vm_init_i (srst),
        .ps2_clk       (ps2_clk),
        .ps2_dat       (ps2_dat),
        .but_data      (but_data),
        .kbd_stb       (kbd_stb),
        .kbd_err       (kbd_err)
    );

    int checks = 0, errors = 0;
    int stb_seen = 0, err_seen = 0, stb_pend = 0, err_pend = 0;
    logic [7:0] exp_data = 8'h00, exp_next = 8'h00;
    bit chk_en = 1'b0;

    // Model state: pending prefixes, bytes left to skip, currently held key (-1 = none).
    bit m_ext = 1'b0, m_brk = 1'b0;
    int m_skip = 0, m_held = -1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_map(input bit ext, input logic [7:0] b);
        if (!ext && b == 8'h1C) return 'o072;
        if (!ext && b == 8'h5A) return 'o153;
        if ( ext && b == 8'h75) return 'o154;
        if (!ext && b == 8'h29) return 'o113;
        return 0;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int code;
        if (m_skip > 0) begin
            m_skip--;
            return;
        end
        if (b == 8'hE0) begin m_ext = 1'b1; return; end
        if (b == 8'hF0) begin m_brk = 1'b1; return; end
        if (!m_ext && !m_brk) begin
            if (b == 8'hE1) begin m_skip = 7; return; end
            if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE || b == 8'h00) return;
        end
        code = model_map(m_ext, b);
        if (code != 0) begin
            if (!m_brk && m_held != code) begin
                m_held = code;
                exp_next = 8'(code);
                stb_pend++;
            end else if (m_brk && m_held == code) begin
                m_held = -1;
                exp_next = 8'h80 | 8'(code);
                stb_pend++;
            end
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stb_err_overlap", int'(kbd_stb & kbd_err), 0);
            if (kbd_stb) begin
                stb_seen++;
                check("stb_expected", int'(stb_pend > 0), 1);
                check("stb_data", but_data, exp_next);
                if (stb_pend > 0) stb_pend--;
                exp_data = exp_next;
            end else begin
                check("data_hold", but_data, exp_data);
            end
            if (kbd_err) begin
                err_seen++;
                check("err_expected", int'(err_pend > 0), 1);
                if (err_pend > 0) err_pend--;
            end
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic par;
        par = (~^b) ^ bad_par;
        if (bad_par) err_pend++;
        else model_byte(b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("stb_missing", stb_pend, 0);
        check("err_missing", err_pend, 0);
        $display("frame %02h parity_bad=%0d but_data=%02h stb_total=%0d err_total=%0d",
                 b, bad_par, but_data, stb_seen, err_seen);
    endtask

    initial begin
        #1ms;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    int stb_mark;
    logic [7:0] pause_seq [8];

    initial begin
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        repeat (4) @(negedge clk);
        check("rst_data", but_data, 0);
        check("rst_stb", kbd_stb, 0);
        check("rst_err", kbd_err, 0);
        srst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;

        send_frame(8'h1C, 1'b0);
        check("make_1c", but_data, 8'h3A);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("break_1c", but_data, 8'hBA);
        check("pulses_1c", stb_seen, 2);

        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("make_e075", but_data, 8'h6C);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("break_e075", but_data, 8'hEC);

        send_frame(8'h1C, 1'b1);
        check("parity_data", but_data, 8'hEC);
        check("parity_err", err_seen, 1);
        check("parity_nostb", stb_seen, 4);

        err_pend++;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_dat = 1'b1;
        repeat (TMO + 1 + 40) @(negedge clk);
        check("timeout_err", err_seen, 2);
        check("timeout_missing", err_pend, 0);
        send_frame(8'h5A, 1'b0);
        check("after_timeout", but_data, 8'h6B);

        stb_mark = stb_seen;
        for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0);
        check("pause_nostb", stb_seen, stb_mark);
        send_frame(8'h29, 1'b0);
        check("after_pause", but_data, 8'h4B);

        stb_mark = stb_seen;
        for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b0);
        check("typematic_pulses", stb_seen - stb_mark, 1);
        check("typematic_data", but_data, 8'h3A);

        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(8'h1C >> i));
        ps2_dat = 1'(8'h1C >> 4);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (15) @(negedge clk);
        chk_en = 1'b0;
        srst = 1'b1;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge clk);
        srst = 1'b0;
        exp_data = 8'h00;
        m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; m_held = -1;
        stb_pend = 0; err_pend = 0;
        @(negedge clk);
        check("midrst_data", but_data, 0);
        check("midrst_stb", kbd_stb, 0);
        check("midrst_err", kbd_err, 0);
        $display("reset mid-frame: but_data=%02h", but_data);
        chk_en = 1'b1;
        repeat (TMO + 60) @(negedge clk);
        check("midrst_no_err", err_seen, 2);

        send_frame(8'h5A, 1'b0);
        check("after_reset", but_data, 8'h6B);
        check("total_stb", stb_seen, 8);
        check("total_err", err_seen, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
